// File: rtl/regfile_debug_arbiter.sv
// Run-control FSM: halts and drains the pipeline, then lends the register file to a debug host.
// Halt takes 1+DRAIN_CYCLES cycles; the response is held until the host accepts it, and commands stall outside HALTED.
module regfile_debug_arbiter #(
   parameter int DRAIN_CYCLES = 3
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        Halt_Req,
   input  logic        Resume_Req,
   output logic        Halted,
   output logic        Stall_FD,
   output logic        Bubble_E,
   input  logic        REG_W_En_W,
   input  logic [4:0]  RD_W,
   input  logic [31:0] Result_W,
   input  logic [4:0]  RS1_D,
   output logic        RF_W_En,
   output logic [4:0]  RF_W_Addr,
   output logic [31:0] RF_W_Data,
   output logic [4:0]  RF_R_Addr1,
   input  logic [31:0] RF_R_Data1,
   input  logic        Dbg_Req_Valid,
   output logic        Dbg_Req_Ready,
   input  logic        Dbg_Req_Write,
   input  logic [4:0]  Dbg_Req_Addr,
   input  logic [31:0] Dbg_Req_Data,
   output logic        Dbg_Rsp_Valid,
   input  logic        Dbg_Rsp_Ready,
   output logic [31:0] Dbg_Rsp_Data
);

   localparam int CW = $clog2(DRAIN_CYCLES + 1);

   localparam logic [1:0] RUN    = 2'd0;
   localparam logic [1:0] DRAIN  = 2'd1;
   localparam logic [1:0] HALTED = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [31:0]   rsp_data;
   logic          cmd_fire;
   logic          dbg_owns_rf;

   assign cmd_fire    = (state == HALTED) && Dbg_Req_Valid;
   assign dbg_owns_rf = (state == HALTED) || (state == RESP);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= RUN;
         cnt      <= '0;
         rsp_data <= '0;
      end else begin
         case (state)
            RUN: begin
               if (Halt_Req) begin
                  state <= DRAIN;
                  cnt   <= CW'(DRAIN_CYCLES);
               end
            end
            DRAIN: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) state <= HALTED;
            end
            HALTED: begin
               // A handshake in the same cycle as a resume takes priority.
               if (cmd_fire) begin
                  state <= RESP;
                  if (Dbg_Req_Write)
                     rsp_data <= (Dbg_Req_Addr != 5'd0) ? Dbg_Req_Data : 32'd0;
                  else
                     rsp_data <= RF_R_Data1;
               end else if (Resume_Req) begin
                  state <= RUN;
               end
            end
            default: begin
               if (Dbg_Rsp_Ready) state <= HALTED;
            end
         endcase
      end
   end

   assign Halted        = dbg_owns_rf;
   assign Stall_FD      = (state != RUN);
   assign Bubble_E      = (state != RUN);
   assign Dbg_Req_Ready = (state == HALTED);
   assign Dbg_Rsp_Valid = (state == RESP);
   assign Dbg_Rsp_Data  = rsp_data;

   always_comb begin
      RF_W_En    = REG_W_En_W;
      RF_W_Addr  = RD_W;
      RF_W_Data  = Result_W;
      RF_R_Addr1 = RS1_D;
      // Pipeline is drained while halted, so writeback is ignored and x0 writes are suppressed.
      if (dbg_owns_rf) begin
         RF_W_En    = cmd_fire && Dbg_Req_Write && (Dbg_Req_Addr != 5'd0);
         RF_W_Addr  = Dbg_Req_Addr;
         RF_W_Data  = Dbg_Req_Data;
         RF_R_Addr1 = Dbg_Req_Addr;
      end
   end

endmodule

// File: tb/tb_regfile_debug_arbiter.sv
// Directed bench for regfile_debug_arbiter with a register-file model and a response scoreboard.
module tb_regfile_debug_arbiter;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        Halt_Req, Resume_Req;
   logic        Halted, Stall_FD, Bubble_E;
   logic        REG_W_En_W;
   logic [4:0]  RD_W, RS1_D;
   logic [31:0] Result_W;
   logic        RF_W_En;
   logic [4:0]  RF_W_Addr, RF_R_Addr1;
   logic [31:0] RF_W_Data, RF_R_Data1;
   logic        Dbg_Req_Valid, Dbg_Req_Ready, Dbg_Req_Write;
   logic [4:0]  Dbg_Req_Addr;
   logic [31:0] Dbg_Req_Data;
   logic        Dbg_Rsp_Valid, Dbg_Rsp_Ready;
   logic [31:0] Dbg_Rsp_Data;

   int errors = 0;
   int checks = 0;
   int wr_count = 0;
   logic [31:0] exp_q[$];
   logic [31:0] rf[32];
   logic [31:0] held;

   always #5 CLK = ~CLK;

   regfile_debug_arbiter #(.DRAIN_CYCLES(3)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .Halt_Req(Halt_Req), .Resume_Req(Resume_Req),
      .Halted(Halted), .Stall_FD(Stall_FD), .Bubble_E(Bubble_E),
      .REG_W_En_W(REG_W_En_W), .RD_W(RD_W), .Result_W(Result_W), .RS1_D(RS1_D),
      .RF_W_En(RF_W_En), .RF_W_Addr(RF_W_Addr), .RF_W_Data(RF_W_Data),
      .RF_R_Addr1(RF_R_Addr1), .RF_R_Data1(RF_R_Data1),
      .Dbg_Req_Valid(Dbg_Req_Valid), .Dbg_Req_Ready(Dbg_Req_Ready),
      .Dbg_Req_Write(Dbg_Req_Write), .Dbg_Req_Addr(Dbg_Req_Addr),
      .Dbg_Req_Data(Dbg_Req_Data),
      .Dbg_Rsp_Valid(Dbg_Rsp_Valid), .Dbg_Rsp_Ready(Dbg_Rsp_Ready),
      .Dbg_Rsp_Data(Dbg_Rsp_Data)
   );

   // Register file model: x0 hard-wired to zero, synchronous write.
   assign RF_R_Data1 = (RF_R_Addr1 == 5'd0) ? 32'd0 : rf[RF_R_Addr1];
   always @(posedge CLK) begin
      if (RF_W_En && RF_W_Addr != 5'd0) begin
         rf[RF_W_Addr] <= RF_W_Data;
         wr_count      <= wr_count + 1;
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_rsp(input string tag);
      int n = 0;
      logic [31:0] e;
      while (!Dbg_Rsp_Valid && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_rsp_valid"}, 32'(Dbg_Rsp_Valid), 32'd1);
      chk({tag, "_sb_depth"}, exp_q.size(), 32'd1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      chk({tag, "_rsp_data"}, Dbg_Rsp_Data, e);
      Dbg_Rsp_Ready = 1'b1;
      tick();
      Dbg_Rsp_Ready = 1'b0;
      chk({tag, "_rsp_done"}, 32'(Dbg_Rsp_Valid), 32'd0);
   endtask

   task automatic do_cmd(input string tag, input logic wr, input logic [4:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rsp);
      int n = 0;
      int w0;
      Dbg_Req_Valid = 1'b1;
      Dbg_Req_Write = wr;
      Dbg_Req_Addr  = a;
      Dbg_Req_Data  = d;
      #1;
      while (!Dbg_Req_Ready && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_req_ready"}, 32'(Dbg_Req_Ready), 32'd1);
      chk({tag, "_rf_w_en"}, 32'(RF_W_En), 32'(wr && a != 5'd0));
      if (wr && a != 5'd0) chk({tag, "_rf_w_addr"}, 32'(RF_W_Addr), 32'(a));
      exp_q.push_back(exp_rsp);
      w0 = wr_count;
      tick();
      Dbg_Req_Valid = 1'b0;
      chk({tag, "_rf_w_en_off"}, 32'(RF_W_En), 32'd0);
      wait_rsp(tag);
      chk({tag, "_rf_writes"}, wr_count - w0, 32'(wr && a != 5'd0));
   endtask

   initial begin
      int n;
      RST_N = 1'b0;
      Halt_Req = 0; Resume_Req = 0;
      REG_W_En_W = 1; RD_W = 5'd3; Result_W = 32'h1111_2222; RS1_D = 5'd7;
      Dbg_Req_Valid = 0; Dbg_Req_Write = 0; Dbg_Req_Addr = 5'd0; Dbg_Req_Data = 0;
      Dbg_Rsp_Ready = 0;
      #3;
      chk("rst_halted",    32'(Halted), 0);
      chk("rst_stall",     32'(Stall_FD), 0);
      chk("rst_bubble",    32'(Bubble_E), 0);
      chk("rst_req_ready", 32'(Dbg_Req_Ready), 0);
      chk("rst_rsp_valid", 32'(Dbg_Rsp_Valid), 0);
      chk("rst_rsp_data",  Dbg_Rsp_Data, 0);
      chk("rst_rf_w_en",   32'(RF_W_En), 1);
      chk("rst_rf_w_addr", 32'(RF_W_Addr), 3);
      chk("rst_rf_w_data", RF_W_Data, 32'h1111_2222);
      chk("rst_rf_r_addr", 32'(RF_R_Addr1), 7);
      REG_W_En_W = 0;
      @(negedge CLK);
      RST_N = 1'b1;
      tick();
      tick();

      // Halt and resume together in RUN: halt wins.
      Halt_Req = 1; Resume_Req = 1;
      tick();
      Halt_Req = 0;
      chk("drain_stall",  32'(Stall_FD), 1);
      chk("drain_bubble", 32'(Bubble_E), 1);
      chk("drain_halted_1", 32'(Halted), 0);
      REG_W_En_W = 1; RD_W = 5'd9; Result_W = 32'h0000_0055;
      #1;
      chk("drain_wb_en",   32'(RF_W_En), 1);
      chk("drain_wb_addr", 32'(RF_W_Addr), 9);
      tick();
      REG_W_En_W = 0;
      chk("drain_halted_2", 32'(Halted), 0);
      tick();
      chk("drain_halted_3", 32'(Halted), 0);
      tick();
      Resume_Req = 0;
      chk("halted_set",   32'(Halted), 1);
      chk("halted_ready", 32'(Dbg_Req_Ready), 1);
      REG_W_En_W = 1; RD_W = 5'd10;
      #1;
      chk("halted_wb_ignored", 32'(RF_W_En), 0);
      REG_W_En_W = 0;

      do_cmd("wr_x5", 1'b1, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      do_cmd("rd_x5", 1'b0, 5'd5, 32'h0, 32'hDEAD_BEEF);
      do_cmd("rd_x9", 1'b0, 5'd9, 32'h0, 32'h0000_0055);
      do_cmd("wr_x0", 1'b1, 5'd0, 32'h1234_5678, 32'h0);
      do_cmd("rd_x0", 1'b0, 5'd0, 32'h0, 32'h0);

      // Backpressure: response held while a second command waits.
      Dbg_Req_Valid = 1; Dbg_Req_Write = 0; Dbg_Req_Addr = 5'd5;
      exp_q.push_back(32'hDEAD_BEEF);
      tick();
      Dbg_Req_Write = 1; Dbg_Req_Addr = 5'd6; Dbg_Req_Data = 32'hA5A5_A5A5;
      held = Dbg_Rsp_Data;
      for (int i = 0; i < 5; i++) begin
         chk("bp_rsp_valid", 32'(Dbg_Rsp_Valid), 1);
         chk("bp_rsp_data",  Dbg_Rsp_Data, held);
         chk("bp_req_ready", 32'(Dbg_Req_Ready), 0);
         tick();
      end
      chk("bp_first_data", Dbg_Rsp_Data, exp_q.pop_front());
      Dbg_Rsp_Ready = 1;
      tick();
      Dbg_Rsp_Ready = 0;
      chk("bp_second_ready", 32'(Dbg_Req_Ready), 1);
      chk("bp_second_wen",   32'(RF_W_En), 1);
      exp_q.push_back(32'hA5A5_A5A5);
      tick();
      Dbg_Req_Valid = 0;
      wait_rsp("bp_second");

      // Command and resume together in HALTED: command wins.
      Dbg_Req_Valid = 1; Dbg_Req_Write = 0; Dbg_Req_Addr = 5'd6;
      Resume_Req = 1;
      exp_q.push_back(32'hA5A5_A5A5);
      tick();
      Dbg_Req_Valid = 0; Resume_Req = 0;
      chk("cmd_vs_resume_halted", 32'(Halted), 1);
      wait_rsp("cmd_vs_resume");

      Resume_Req = 1;
      tick();
      Resume_Req = 0;
      chk("resume_halted", 32'(Halted), 0);
      chk("resume_stall",  32'(Stall_FD), 0);
      chk("resume_bubble", 32'(Bubble_E), 0);
      RS1_D = 5'd11;
      #1;
      chk("resume_rf_r_addr", 32'(RF_R_Addr1), 11);

      // Asynchronous reset while a response is pending.
      Halt_Req = 1;
      tick();
      Halt_Req = 0;
      n = 0;
      while (!Halted && n < 20) begin
         tick();
         n++;
      end
      chk("rehalt", 32'(Halted), 1);
      Dbg_Req_Valid = 1; Dbg_Req_Write = 0; Dbg_Req_Addr = 5'd5;
      tick();
      Dbg_Req_Valid = 0;
      chk("pre_rst_rsp_valid", 32'(Dbg_Rsp_Valid), 1);
      #2;
      RST_N = 1'b0;
      #1;
      chk("async_rst_rsp_valid", 32'(Dbg_Rsp_Valid), 0);
      chk("async_rst_halted",    32'(Halted), 0);
      chk("async_rst_stall",     32'(Stall_FD), 0);
      exp_q.delete();
      @(negedge CLK);
      RST_N = 1'b1;
      tick();
      chk("post_rst_halted",    32'(Halted), 0);
      chk("post_rst_stall",     32'(Stall_FD), 0);
      chk("post_rst_req_ready", 32'(Dbg_Req_Ready), 0);
      chk("post_rst_rsp_data",  Dbg_Rsp_Data, 0);
      RS1_D = 5'd13;
      #1;
      chk("post_rst_rf_r_addr", 32'(RF_R_Addr1), 13);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
